ladybird_mem_arbiter: RTL

- Shares the single memory request/response channel of ladybird_mmu between two requesters: instruction fetch (I port, read-only) and load/store (D port).
- Allows one transaction outstanding at a time.
- D has fixed priority, with a starvation guard so fetch is never locked out.
- Sits between the core pipeline and the MMU/AXI side; routes each response back to the requester that issued it, and drops fetch responses after a fetch flush (branch redirect).

---
 rtl/ladybird_mem_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ladybird_mem_arbiter.sv
// Two-requester arbiter in front of the ladybird_mmu memory channel: load/store has
// priority, fetch is forced after MAX_STARVE back-to-back data grants, one transaction in flight.
module ladybird_mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic            clk,
  input  logic            nrst,
  // instruction fetch port
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [XLEN-1:0] i_addr,
  input  logic            i_flush,
  output logic            i_rvalid,
  output logic [XLEN-1:0] i_rdata,
  // load/store port
  input  logic            d_valid,
  output logic            d_ready,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_data,
  input  logic            d_we,
  input  logic [2:0]      d_funct,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  // downstream (MMU) channel
  output logic            m_valid,
  input  logic            m_ready,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_data,
  output logic            m_we,
  output logic [2:0]      m_funct,
  input  logic            m_rvalid,
  input  logic [XLEN-1:0] m_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);
  localparam logic [2:0] FUNCT_WORD = 3'b010;

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       drop, drop_nxt;

  logic sel_i, sel_d, i_acc, d_acc;

  // Fetch wins only when data is idle or data has used up its consecutive-grant allowance.
  assign sel_i = (state == IDLE) & i_valid & (~d_valid | (starve_cnt == STARVE_MAX));
  assign sel_d = (state == IDLE) & d_valid & ~sel_i;
  assign i_acc = sel_i & m_ready;
  assign d_acc = sel_d & m_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      drop       <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      drop       <= drop_nxt;
    end
  end

  // NOTE: every variable assigned in a combinational block gets a default first,
  // otherwise paths that skip an assignment infer latches.
  always_comb begin
    state_nxt  = state;
    drop_nxt   = drop;
    starve_nxt = starve_cnt;

    unique case (state)
      IDLE: begin
        drop_nxt = 1'b0;
        if (i_acc)      state_nxt = BUSY_I;
        else if (d_acc) state_nxt = BUSY_D;
      end
      BUSY_I: begin
        if (i_flush) drop_nxt = 1'b1;
        if (m_rvalid) begin
          state_nxt = IDLE;
          drop_nxt  = 1'b0;
        end
      end
      BUSY_D: begin
        if (m_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (!i_valid || i_acc)
      starve_nxt = '0;
    else if (d_acc && (starve_cnt != STARVE_MAX))
      starve_nxt = starve_cnt + 4'd1;
  end

  always_comb begin
    m_valid  = sel_i | sel_d;
    m_addr   = '0;
    m_data   = '0;
    m_we     = 1'b0;
    m_funct  = 3'b000;
    i_ready  = i_acc;
    d_ready  = d_acc;
    i_rvalid = 1'b0;
    i_rdata  = '0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    busy     = (state != IDLE);

    if (sel_i) begin
      m_addr  = i_addr;
      m_funct = FUNCT_WORD;
    end else if (sel_d) begin
      m_addr  = d_addr;
      m_data  = d_data;
      m_we    = d_we;
      m_funct = d_funct;
    end

    // A flush landing on the response cycle itself also discards that response.
    if ((state == BUSY_I) && m_rvalid && !(drop || i_flush)) begin
      i_rvalid = 1'b1;
      i_rdata  = m_rdata;
    end
    if ((state == BUSY_D) && m_rvalid) begin
      d_rvalid = 1'b1;
      d_rdata  = m_rdata;
    end
  end

endmodule
